// File: rtl/spike_fifo_dispatcher.sv
// spike_fifo_dispatcher: pops spike packets from the node FIFO and hands each to one output port
// Ports:
//   Clk, Rst            clock, asynchronous active-high reset
//   EN                  enable for new FIFO reads; an in-flight packet always completes
//   fifo_dataOut/EMPTY  FIFO read data (valid the cycle after fifo_RD) and empty flag
//   fifo_RD             one-cycle read strobe per packet
//   out_data/out_valid  shared packet bus and one-hot per-port valid
//   out_ready           per-port ready; only the destination bit is looked at
//   busy                high outside IDLE
//   drop_pulse          one-cycle pulse when a packet with an out-of-range destination is discarded
//   fwd_count/drop_count  saturating event counters, present only with SPIKE_DISPATCH_STATS_EN
module spike_fifo_dispatcher #(
    parameter int DATA_W    = 32,
    parameter int NUM_PORTS = 4,
    parameter int DEST_W    = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 EN,
    input  logic [DATA_W-1:0]    fifo_dataOut,
    input  logic                 fifo_EMPTY,
    output logic                 fifo_RD,
    output logic [DATA_W-1:0]    out_data,
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output logic                 busy,
    output logic                 drop_pulse
`ifdef SPIKE_DISPATCH_STATS_EN
    ,
    output logic [15:0]          fwd_count,
    output logic [15:0]          drop_count
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pkt_q;
    logic [DEST_W-1:0]   in_dest, pkt_dest;
    logic                in_ok, done;
    assign in_dest  = fifo_dataOut[DATA_W-1 -: DEST_W];
    assign pkt_dest = pkt_q[DATA_W-1 -: DEST_W];
    assign in_ok    = 32'(in_dest) < NUM_PORTS;
    // out_valid is one-hot on the destination, so this is the destination port's handshake only
    assign done     = |(out_valid & out_ready);
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    // fifo_RD already folds in "IDLE, or SEND completing", so it alone picks FETCH vs IDLE
    always_comb begin
        state_d = (state_q == FETCH)         ? (in_ok ? SEND : IDLE) :
                  (state_q == SEND && !done) ? SEND :
                  fifo_RD                    ? FETCH : IDLE;
    end
    always_comb begin
        fifo_RD    = EN && !fifo_EMPTY && (state_q == IDLE || done);
        out_valid  = (state_q == SEND) ? NUM_PORTS'(1) << pkt_dest : '0;
        out_data   = pkt_q;
        busy       = state_q != IDLE;
        drop_pulse = state_q == FETCH && !in_ok;
    end
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                 pkt_q <= '0;
        else if (state_q == FETCH) pkt_q <= fifo_dataOut;
    end
`ifdef SPIKE_DISPATCH_STATS_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            fwd_count  <= '0;
            drop_count <= '0;
        end else begin
            fwd_count  <= fwd_count + 16'(done && fwd_count != 16'hFFFF);
            drop_count <= drop_count + 16'(drop_pulse && drop_count != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_spike_fifo_dispatcher.sv
// tb_spike_fifo_dispatcher: directed bench with a FIFO model and a delivery scoreboard
module tb_spike_fifo_dispatcher;
    logic        Clk = 0, Rst = 1, EN = 0;
    logic [31:0] fifo_dataOut = 0, out_data;
    logic        fifo_EMPTY, fifo_RD, busy, drop_pulse;
    logic [3:0]  out_valid, out_ready = 0;
`ifdef SPIKE_DISPATCH_STATS_EN
    logic [15:0] fwd_count, drop_count;
`endif
    logic [31:0] mem [0:63];
    int          wr_n = 0, rd_n = 0;
    int          passed = 0, total = 0;
    logic [35:0] exp_q [$];
    logic [35:0] e;

    always #5 Clk = ~Clk;

    assign fifo_EMPTY = (wr_n == rd_n);
    always @(posedge Clk) if (fifo_RD) begin
        fifo_dataOut <= mem[rd_n[5:0]];
        rd_n <= rd_n + 1;
    end

    spike_fifo_dispatcher dut (
        .Clk(Clk), .Rst(Rst), .EN(EN),
        .fifo_dataOut(fifo_dataOut), .fifo_EMPTY(fifo_EMPTY), .fifo_RD(fifo_RD),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .drop_pulse(drop_pulse)
`ifdef SPIKE_DISPATCH_STATS_EN
        , .fwd_count(fwd_count), .drop_count(drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] d);
        mem[wr_n[5:0]] = d;
        wr_n++;
        if (d[31:28] < 4'd4) exp_q.push_back({4'b0001 << d[31:28], d});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
        chk("idle_reached", 64'(busy), 0);
    endtask

    always @(negedge Clk) if (!Rst) begin
        chk("rd_while_empty", 64'(fifo_RD & fifo_EMPTY), 0);
        if (|(out_valid & out_ready)) begin
            if (exp_q.size() == 0) chk("unexpected_handshake", {out_valid, out_data}, 0);
            else begin
                e = exp_q.pop_front();
                chk("sb_data", 64'(out_data), 64'(e[31:0]));
                chk("sb_valid", 64'(out_valid), 64'(e[35:32]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        int base, k;
        int at [5];
        int dl [5] = '{0, 1, 2, 3, 0};
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_state", {fifo_RD, busy, drop_pulse, out_valid, out_data}, 0);
        Rst = 0;
        EN  = 1;
        repeat (10) begin
            @(negedge Clk);
            chk("idle_quiet", {fifo_RD, busy, drop_pulse, out_valid}, 0);
        end
        // single packet
        @(posedge Clk); #1;
        out_ready = 4'hF;
        base = rd_n;
        push(32'h2000_00AB);
        @(negedge Clk); chk("single_rd", 64'(fifo_RD), 1);
        @(negedge Clk); chk("single_fetch", {fifo_RD, busy, out_valid}, 6'b010000);
        @(negedge Clk); chk("single_valid", 64'(out_valid), 4'b0100);
        chk("single_data", 64'(out_data), 32'h2000_00AB);
        @(negedge Clk); chk("single_done", {busy, out_valid}, 0);
        chk("single_rd_count", 64'(rd_n - base), 1);
        // back-to-back
        @(posedge Clk); #1;
        base = rd_n;
        for (int i = 0; i < 5; i++) push({4'(dl[i]), 28'hA0 + 28'(i)});
        k = 0;
        for (int i = 0; i < 40 && k < 5; i++) begin
            @(negedge Clk);
            if (|(out_valid & out_ready)) begin
                at[k] = i;
                k++;
            end
        end
        chk("b2b_handshakes", 64'(k), 5);
        for (int j = 1; j < 5; j++) chk("b2b_spacing", 64'(at[j] - at[j-1]), 2);
        wait_idle();
        chk("b2b_rd_count", 64'(rd_n - base), 5);
        // backpressure with a second packet waiting
        @(posedge Clk); #1;
        out_ready = 4'b1101;
        base = rd_n;
        push(32'h1234_5678);
        push(32'h2BAD_0002);
        @(negedge Clk);
        @(negedge Clk);
        repeat (6) begin
            @(negedge Clk);
            chk("bp_valid", 64'(out_valid), 4'b0010);
            chk("bp_data", 64'(out_data), 32'h1234_5678);
            chk("bp_no_rd", 64'(fifo_RD), 0);
        end
        @(posedge Clk); #1;
        out_ready = 4'hF;
        @(negedge Clk);
        chk("bp_valid_last", 64'(out_valid), 4'b0010);
        chk("bp_data_last", 64'(out_data), 32'h1234_5678);
        chk("bp_complete_rd", 64'(fifo_RD), 1);
        wait_idle();
        chk("bp_rd_count", 64'(rd_n - base), 2);
        // invalid destination after a clean reset
        @(posedge Clk); #1; Rst = 1;
        @(posedge Clk); #1; Rst = 0;
        base = rd_n;
        push(32'h7000_0001);
        @(negedge Clk); chk("inv_rd", 64'(fifo_RD), 1);
        @(negedge Clk); chk("inv_drop", {drop_pulse, out_valid}, 5'b10000);
        @(negedge Clk); chk("inv_after", {drop_pulse, busy, out_valid}, 0);
`ifdef SPIKE_DISPATCH_STATS_EN
        chk("drop_count", 64'(drop_count), 1);
        chk("fwd_count", 64'(fwd_count), 0);
`endif
        // reset while in SEND
        @(posedge Clk); #1;
        out_ready = 4'b0000;
        push(32'h0000_0C0D);
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk); chk("rs_valid", 64'(out_valid), 4'b0001);
        #2 Rst = 1;
        #1 chk("rs_async", {out_valid, busy, fifo_RD}, 0);
        exp_q.delete();
        @(posedge Clk); #1; Rst = 0;
        @(negedge Clk); chk("rs_idle", {busy, out_valid}, 0);
        // EN dropped during FETCH
        @(posedge Clk); #1;
        out_ready = 4'hF;
        base = rd_n;
        for (int i = 0; i < 4; i++) push({4'(i), 28'h0E0 + 28'(i)});
        @(negedge Clk); chk("en_rd", 64'(fifo_RD), 1);
        @(posedge Clk); #1; EN = 0;
        @(negedge Clk); chk("en_fetch", {fifo_RD, busy}, 2'b01);
        @(negedge Clk); chk("en_deliver", 64'(out_valid), 4'b0001);
        chk("en_no_rd", 64'(fifo_RD), 0);
        repeat (8) @(negedge Clk);
        chk("en_parked", {busy, out_valid}, 0);
        chk("en_rd_count", 64'(rd_n - base), 1);
        chk("en_left_in_fifo", 64'(exp_q.size()), 3);
`ifdef SPIKE_DISPATCH_STATS_EN
        chk("fwd_count_end", 64'(fwd_count), 1);
`endif
        exp_q.delete();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
